// File: rtl/pipe_muldiv_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pipe_muldiv_seq                                                 |
// | Purpose  : Sequencer for the shared iterative multiply/divide unit that    |
// |            sits beside the EX-stage ALU. Runs MULT/MULTU/DIV/DIVU one bit  |
// |            per cycle (shift-add / restoring division), stalls the pipe     |
// |            until HI/LO are written, and serves MTHI/MTLO/MFHI/MFLO.        |
// | Ports    : clock, resetn (async, active-low)                               |
// |            estart, eop[1:0], ea, eb   - op request and operands from EX    |
// |            ewhi, ewlo                 - MTHI / MTLO write requests         |
// |            ecancel                    - EX flush, aborts op in flight      |
// |            estall                     - combinational pipeline freeze      |
// |            edone                      - 1-cycle pulse on mul/div writeback |
// |            hi, lo                     - architectural HI/LO registers      |
// | Option   : MULDIV_EARLY_OUT_EN - zero-operand ops skip the RUN loop        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module pipe_muldiv_seq #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic            estart,
  input  logic [1:0]      eop,
  input  logic [XLEN-1:0] ea,
  input  logic [XLEN-1:0] eb,
  input  logic            ewhi,
  input  logic            ewlo,
  input  logic            ecancel,
  output logic            estall,
  output logic            edone,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  count;
  // Multiply: {partial product, multiplier}. Divide: {remainder, dividend/quotient}.
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   opb;       // multiplicand or divisor magnitude
  logic [XLEN-1:0]   a_raw;     // unmodified ea, returned in HI on divide by zero
  logic              is_div;
  logic              neg_q;     // negate product / quotient at writeback
  logic              neg_r;     // negate remainder at writeback
  logic              div_zero;
  logic              skip_wb;   // early-out already wrote HI/LO

  // Operand decode in IDLE
  logic            op_div;
  logic            op_signed;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic            early;

  assign op_div    = eop[1];
  assign op_signed = ~eop[0];
  assign a_neg     = op_signed & ea[XLEN-1];
  assign b_neg     = op_signed & eb[XLEN-1];
  assign a_mag     = a_neg ? -ea : ea;
  assign b_mag     = b_neg ? -eb : eb;

`ifdef MULDIV_EARLY_OUT_EN
  // Divide by zero never qualifies: it must still return ea in HI.
  assign early = op_div ? ((ea == '0) && (eb != '0)) : ((ea == '0) || (eb == '0));
`else
  assign early = 1'b0;
`endif

  // One iteration step
  logic [XLEN:0] mul_sum;
  logic [XLEN:0] div_diff;

  assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? opb : '0)};
  // acc[2*XLEN-1:XLEN-1] is the remainder after shifting in the next dividend bit.
  assign div_diff = acc[2*XLEN-1:XLEN-1] - {1'b0, opb};

  // Sign fix-up applied at writeback
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;

  assign prod_fix = neg_q ? -acc : acc;
  assign quo_fix  = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
  assign rem_fix  = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];

  // DONE keeps estall low so EX can retire the mul/div; a pending MTHI/MTLO
  // still stalls there because the write can only happen in IDLE.
  assign estall = ((state == ST_IDLE) & estart & ~ecancel)
                | (state == ST_RUN)
                | ((state != ST_IDLE) & (ewhi | ewlo));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      count    <= '0;
      acc      <= '0;
      opb      <= '0;
      a_raw    <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      skip_wb  <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      edone    <= 1'b0;
    end else begin
      edone <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (estart && !ecancel) begin
            count    <= '0;
            acc      <= {{XLEN{1'b0}}, a_mag};
            opb      <= b_mag;
            a_raw    <= ea;
            is_div   <= op_div;
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= a_neg;
            div_zero <= op_div & (eb == '0);
            if (early) begin
              state   <= ST_DONE;
              skip_wb <= 1'b1;
              hi      <= '0;
              lo      <= '0;
              edone   <= 1'b1;
            end else begin
              state   <= ST_RUN;
              skip_wb <= 1'b0;
            end
          end else if (!estart) begin
            if (ewhi) hi <= ea;
            if (ewlo) lo <= ea;
          end
        end

        ST_RUN: begin
          if (ecancel) begin
            state <= ST_IDLE;
          end else begin
            if (is_div) begin
              if (!div_diff[XLEN]) begin
                acc <= {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
              end else begin
                acc <= {acc[2*XLEN-2:0], 1'b0};
              end
            end else begin
              acc <= {mul_sum, acc[XLEN-1:1]};
            end
            if (count == CNT_W'(XLEN-1)) begin
              state <= ST_DONE;
            end else begin
              count <= count + 1'b1;
            end
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
          if (!ecancel && !skip_wb) begin
            edone <= 1'b1;
            if (!is_div) begin
              {hi, lo} <= prod_fix;
            end else if (div_zero) begin
              hi <= a_raw;
              lo <= '1;
            end else begin
              hi <= rem_fix;
              lo <= quo_fix;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_muldiv_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_pipe_muldiv_seq                                              |
// | Purpose  : Self-checking bench for pipe_muldiv_seq. A cycle-level model    |
// |            computes results with plain 64-bit arithmetic and tracks op     |
// |            progress by elapsed cycles; directed vectors pin literal values.|
// | Option   : MULDIV_EARLY_OUT_EN - adds the early-out vector and model rule  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_pipe_muldiv_seq;
  localparam int XLEN = 32;

  logic        clock   = 1'b0;
  logic        resetn  = 1'b1;
  logic        estart  = 1'b0;
  logic [1:0]  eop     = 2'd0;
  logic [31:0] ea      = '0;
  logic [31:0] eb      = '0;
  logic        ewhi    = 1'b0;
  logic        ewlo    = 1'b0;
  logic        ecancel = 1'b0;
  logic        estall;
  logic        edone;
  logic [31:0] hi;
  logic [31:0] lo;

  int errors = 0;
  int checks = 0;

  pipe_muldiv_seq #(.XLEN(32), .CNT_W(6)) dut (
    .clock   (clock),
    .resetn  (resetn),
    .estart  (estart),
    .eop     (eop),
    .ea      (ea),
    .eb      (eb),
    .ewhi    (ewhi),
    .ewlo    (ewlo),
    .ecancel (ecancel),
    .estall  (estall),
    .edone   (edone),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Architectural result: {hi, lo}
  function automatic logic [63:0] calc(input logic [1:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
    longint sa, sb, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'd0: return sa * sb;
      2'd1: return {32'h0, a} * {32'h0, b};
      2'd2: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Model: m_k = 0 idle, 1..XLEN iterating, XLEN+1 writeback cycle.
  int          m_k = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic        m_edone = 1'b0;
  logic        m_skip = 1'b0;
  logic [63:0] m_res = '0;

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      m_k     <= 0;
      m_hi    <= '0;
      m_lo    <= '0;
      m_edone <= 1'b0;
      m_skip  <= 1'b0;
    end else begin
      m_edone <= 1'b0;
      if (m_k == 0) begin
        if (estart && !ecancel) begin
          m_res  <= calc(eop, ea, eb);
          m_k    <= 1;
          m_skip <= 1'b0;
`ifdef MULDIV_EARLY_OUT_EN
          if (eop[1] ? (ea == 0 && eb != 0) : (ea == 0 || eb == 0)) begin
            m_hi    <= '0;
            m_lo    <= '0;
            m_edone <= 1'b1;
            m_k     <= XLEN + 1;
            m_skip  <= 1'b1;
          end
`endif
        end else if (!estart) begin
          if (ewhi) m_hi <= ea;
          if (ewlo) m_lo <= ea;
        end
      end else if (ecancel) begin
        m_k <= 0;
      end else if (m_k == XLEN + 1) begin
        if (!m_skip) begin
          m_hi    <= m_res[63:32];
          m_lo    <= m_res[31:0];
          m_edone <= 1'b1;
        end
        m_k <= 0;
      end else begin
        m_k <= m_k + 1;
      end
    end
  end

  logic exp_stall;
  assign exp_stall = (m_k == 0 && estart && !ecancel) || (m_k >= 1 && m_k <= XLEN)
                   || (m_k != 0 && (ewhi || ewlo));

  always @(negedge clock) begin
    if (resetn) begin
      chk("model_hi", hi, m_hi);
      chk("model_lo", lo, m_lo);
      chk("model_edone", edone, m_edone);
      chk("model_estall", estall, exp_stall);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Issue an op, hold estart until estall drops, then check the writeback cycle.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] xh, input logic [31:0] xl, input string name);
    int stalls;
    bit rel;
    stalls = 0;
    rel    = 1'b0;
    tick();
    estart = 1'b1; eop = op; ea = a; eb = b;
    for (int i = 0; i < 60 && !rel; i++) begin
      @(negedge clock);
      if (estall) stalls++;
      else rel = 1'b1;
    end
    chk({name, "_stall_cycles"}, stalls, 33);
    tick();
    estart = 1'b0;
    @(negedge clock);
    chk({name, "_edone"}, edone, 1);
    chk({name, "_hi"}, hi, xh);
    chk({name, "_lo"}, lo, xl);
  endtask

  initial begin
    int ed;
    #2 resetn = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_hi", hi, 0);
    chk("reset_lo", lo, 0);
    chk("reset_estall", estall, 0);
    chk("reset_edone", edone, 0);
    resetn = 1'b1;

    do_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max");
    do_op(2'd0, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_neg");
    do_op(2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, "mult_minmin");
    do_op(2'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg_a");
    do_op(2'd3, 32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF, "divu_zero");
    do_op(2'd2, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, "div_zero_neg");
    do_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, "div_ovf");
    do_op(2'd3, 32'hFFFF_FFFF, 32'd3,         32'h0000_0000, 32'h5555_5555, "divu_big");
    do_op(2'd2, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, "div_neg_b");

    // Cancel mid-RUN: HI/LO keep the previous result, no edone.
    tick();
    estart = 1'b1; eop = 2'd0; ea = 32'd5; eb = 32'd6;
    repeat (10) tick();
    ecancel = 1'b1; estart = 1'b0;
    tick();
    ecancel = 1'b0;
    @(negedge clock);
    chk("cancel_estall", estall, 0);
    ed = 0;
    repeat (40) begin
      @(negedge clock);
      if (edone) ed++;
    end
    chk("cancel_no_edone", ed, 0);
    chk("cancel_hi", hi, 32'h0000_0001);
    chk("cancel_lo", lo, 32'hFFFF_FFFD);

    // MTHI while busy: stalls through DONE, written in the following IDLE cycle.
    tick();
    estart = 1'b1; eop = 2'd3; ea = 32'd100; eb = 32'd7;
    tick();
    estart = 1'b0; ea = 32'd0;
    repeat (4) tick();
    ewhi = 1'b1; ea = 32'h0000_1234;
    repeat (29) tick();
    @(negedge clock);
    chk("mthi_busy_edone", edone, 1);
    chk("mthi_busy_hi_div", hi, 32'd2);
    chk("mthi_busy_lo_div", lo, 32'd14);
    tick();
    ewhi = 1'b0;
    @(negedge clock);
    chk("mthi_busy_hi", hi, 32'h0000_1234);
    chk("mthi_busy_lo", lo, 32'd14);
    tick();
    ewhi = 1'b1; ewlo = 1'b1; ea = 32'h0000_CAFE;
    tick();
    ewhi = 1'b0; ewlo = 1'b0;
    @(negedge clock);
    chk("mthilo_hi", hi, 32'h0000_CAFE);
    chk("mthilo_lo", lo, 32'h0000_CAFE);

    // Asynchronous reset in the middle of a divide.
    tick();
    estart = 1'b1; eop = 2'd2; ea = 32'hFFFF_FF9C; eb = 32'd3;
    repeat (8) tick();
    estart = 1'b0;
    #1 resetn = 1'b0;
    #1;
    chk("async_rst_hi", hi, 0);
    chk("async_rst_lo", lo, 0);
    chk("async_rst_estall", estall, 0);
    chk("async_rst_edone", edone, 0);
    #1 resetn = 1'b1;
    do_op(2'd2, 32'hFFFF_FF9C, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFDF, "div_after_rst");

`ifdef MULDIV_EARLY_OUT_EN
    tick();
    estart = 1'b1; eop = 2'd0; ea = 32'd0; eb = 32'd9;
    tick();
    estart = 1'b0;
    @(negedge clock);
    chk("early_edone", edone, 1);
    chk("early_hi", hi, 0);
    chk("early_lo", lo, 0);
    chk("early_estall", estall, 0);
`endif

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
